// File: rtl/rtc_bus_cycle.sv
// Bus-cycle generator for the RTC multiplexed address/data bus: one address
// phase, a gap, then a data phase, each timed in clk cycles; all outputs registered.
module rtc_bus_cycle #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 4,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_GAP   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       escritura,
    input  logic       lectura,
    input  logic [7:0] dir,
    input  logic [7:0] dato,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] dato_leido,
    output logic       fin,
    output logic       ocupado
);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] dir_q, dir_d;
    logic [7:0] dato_q, dato_d;
    logic       wr_op_q, wr_op_d;
    logic [7:0] dato_leido_q, dato_leido_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       a_d_q, a_d_d;
    logic       fin_q, fin_d;
    logic       ocupado_q, ocupado_d;
    logic       last;

    function automatic logic [3:0] reload(input state_t s);
        case (s)
            A_SETUP, D_SETUP:   reload = 4'(T_SETUP - 1);
            A_STROBE, D_STROBE: reload = 4'(T_PULSE - 1);
            A_HOLD, D_HOLD:     reload = 4'(T_HOLD - 1);
            GAP:                reload = 4'(T_GAP - 1);
            default:            reload = '0;
        endcase
    endfunction

    assign last = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dato_d  = dato_q;
        wr_op_d = wr_op_q;
        case (state_q)
            IDLE: begin
                if (escritura || lectura) begin
                    state_d = A_SETUP;
                    dir_d   = dir;
                    dato_d  = dato;
                    wr_op_d = escritura;
                end
            end
            A_SETUP:  if (last) state_d = A_STROBE;
            A_STROBE: if (last) state_d = A_HOLD;
            A_HOLD:   if (last) state_d = GAP;
            GAP:      if (last) state_d = D_SETUP;
            D_SETUP:  if (last) state_d = D_STROBE;
            D_STROBE: if (last) state_d = D_HOLD;
            D_HOLD:   if (last) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = reload(state_d);
        end else if (!last) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end

        dato_leido_d = dato_leido_q;
        if (state_q == D_STROBE && last && !wr_op_q) begin
            dato_leido_d = ad_in;
        end
    end

    // Bus outputs are decoded from the next state so the pins change on the
    // same edge as the state register.
    always_comb begin
        cs_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        a_d_d     = 1'b1;
        ad_oe_d   = 1'b0;
        ad_out_d  = '0;
        fin_d     = 1'b0;
        ocupado_d = (state_d != IDLE);
        case (state_d)
            A_SETUP, A_STROBE, A_HOLD: begin
                cs_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = dir_d;
                wr_n_d   = (state_d != A_STROBE);
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                cs_n_d = 1'b0;
                if (wr_op_d) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = dato_d;
                    wr_n_d   = (state_d != D_STROBE);
                end else begin
                    rd_n_d = (state_d != D_STROBE);
                end
            end
            DONE:    fin_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dir_q        <= '0;
            dato_q       <= '0;
            wr_op_q      <= 1'b0;
            dato_leido_q <= '0;
            ad_out_q     <= '0;
            ad_oe_q      <= 1'b0;
            cs_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            a_d_q        <= 1'b1;
            fin_q        <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            dato_q       <= dato_d;
            wr_op_q      <= wr_op_d;
            dato_leido_q <= dato_leido_d;
            ad_out_q     <= ad_out_d;
            ad_oe_q      <= ad_oe_d;
            cs_n_q       <= cs_n_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            a_d_q        <= a_d_d;
            fin_q        <= fin_d;
            ocupado_q    <= ocupado_d;
        end
    end

    assign ad_out     = ad_out_q;
    assign ad_oe      = ad_oe_q;
    assign cs_n       = cs_n_q;
    assign rd_n       = rd_n_q;
    assign wr_n       = wr_n_q;
    assign a_d        = a_d_q;
    assign dato_leido = dato_leido_q;
    assign fin        = fin_q;
    assign ocupado    = ocupado_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Scoreboard bench for rtc_bus_cycle: a default-timing instance and an
// all-ones-timing instance, with per-cycle protocol checks on both.
module tb_rtc_bus_cycle;

    typedef struct {
        int         cyc;
        logic [7:0] rd;
        int         wa;
        int         wd;
        int         rn;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    logic [1:0] esc, lec;
    logic [7:0] dir_i [2];
    logic [7:0] dato_i [2];
    logic [7:0] rdv [2];
    logic [7:0] ad_in [2];
    logic [7:0] ad_out [2];
    logic [7:0] dato_leido [2];
    logic [1:0] ad_oe, cs_n, rd_n, wr_n, a_d, fin, ocupado;

    exp_t q0[$];
    exp_t q1[$];
    int   lat [2] = '{19, 7};
    int   pw  [2] = '{4, 1};
    int   gpx [2] = '{3, 1};
    int   wa [2], wd [2], rn [2], gp [2];
    logic [7:0] exp_dir [2];
    logic [7:0] exp_dato [2];
    logic [7:0] last_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The RTC pad returns the selected byte only while rd_n is low.
    assign ad_in[0] = rd_n[0] ? 8'hFF : rdv[0];
    assign ad_in[1] = rd_n[1] ? 8'hFF : rdv[1];

    rtc_bus_cycle dut0 (
        .clk(clk), .reset(rst_n), .escritura(esc[0]), .lectura(lec[0]),
        .dir(dir_i[0]), .dato(dato_i[0]), .ad_in(ad_in[0]), .ad_out(ad_out[0]),
        .ad_oe(ad_oe[0]), .cs_n(cs_n[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0]),
        .a_d(a_d[0]), .dato_leido(dato_leido[0]), .fin(fin[0]), .ocupado(ocupado[0])
    );

    rtc_bus_cycle #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut1 (
        .clk(clk), .reset(rst_n), .escritura(esc[1]), .lectura(lec[1]),
        .dir(dir_i[1]), .dato(dato_i[1]), .ad_in(ad_in[1]), .ad_out(ad_out[1]),
        .ad_oe(ad_oe[1]), .cs_n(cs_n[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1]),
        .a_d(a_d[1]), .dato_leido(dato_leido[1]), .fin(fin[1]), .ocupado(ocupado[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic clear_cnt(input int d);
        wa[d] = 0; wd[d] = 0; rn[d] = 0; gp[d] = 0;
    endtask

    task automatic expect_txn(input int d, input int k, input bit w, input logic [7:0] rv);
        exp_t e;
        if (!w) last_rd[d] = rv;
        e.cyc = k + lat[d];
        e.rd  = last_rd[d];
        e.wa  = pw[d];
        e.wd  = w ? pw[d] : 0;
        e.rn  = w ? 0 : pw[d];
        e.gap = gpx[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Drives a request at a falling edge; returns the acceptance edge number.
    task automatic drive(input int d, input bit w, input bit r, input logic [7:0] a,
                         input logic [7:0] dt, input logic [7:0] rv, output int k);
        @(negedge clk);
        esc[d] = w; lec[d] = r; dir_i[d] = a; dato_i[d] = dt; rdv[d] = rv;
        exp_dir[d] = a; exp_dato[d] = dt;
        k = cyc + 1;
    endtask

    task automatic drop(input int d);
        @(negedge clk);
        esc[d] = 1'b0; lec[d] = 1'b0;
    endtask

    task automatic mon(input int d);
        exp_t e;
        bool_chk: begin
            if (!rst_n) begin
                clear_cnt(d);
                disable bool_chk;
            end
            chk($sformatf("invariants_dut%0d", d),
                {31'd0, !(rd_n[d] == 1'b0 && wr_n[d] == 1'b0)} +
                {31'd0, !(cs_n[d] && (!rd_n[d] || !wr_n[d]))} +
                {31'd0, !(!rd_n[d] && ad_oe[d])}, 32'd3);
            if (!wr_n[d]) begin
                chk($sformatf("wr_drive_dut%0d", d), {23'd0, ad_oe[d], ad_out[d]},
                    {23'd0, 1'b1, (a_d[d] ? exp_dato[d] : exp_dir[d])});
                if (a_d[d]) wd[d]++;
                else        wa[d]++;
            end
            if (!rd_n[d]) rn[d]++;
            if (ocupado[d] && cs_n[d] && !fin[d]) gp[d]++;
            if (fin[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    total++;
                    bad++;
                    $display("FAIL fin_unexpected dut%0d: fin=1 at cycle %0d, required no fin", d, cyc);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("fin_cycle_dut%0d", d), cyc, e.cyc);
                    chk($sformatf("dato_leido_dut%0d", d), {24'd0, dato_leido[d]}, {24'd0, e.rd});
                    chk($sformatf("wr_addr_len_dut%0d", d), wa[d], e.wa);
                    chk($sformatf("wr_data_len_dut%0d", d), wd[d], e.wd);
                    chk($sformatf("rd_len_dut%0d", d), rn[d], e.rn);
                    chk($sformatf("gap_len_dut%0d", d), gp[d], e.gap);
                end
                clear_cnt(d);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    initial begin
        int k;
        rst_n = 1'b1;
        esc = '0; lec = '0;
        for (int d = 0; d < 2; d++) begin
            dir_i[d] = '0; dato_i[d] = '0; rdv[d] = '0;
            exp_dir[d] = '0; exp_dato[d] = '0; last_rd[d] = '0;
            clear_cnt(d);
        end
        #1 rst_n = 1'b0;
        #2;
        chk("rst_cs_n", {31'd0, cs_n[0]}, 32'd1);
        chk("rst_rd_n", {31'd0, rd_n[0]}, 32'd1);
        chk("rst_wr_n", {31'd0, wr_n[0]}, 32'd1);
        chk("rst_a_d", {31'd0, a_d[0]}, 32'd1);
        chk("rst_ad_oe", {31'd0, ad_oe[0]}, 32'd0);
        chk("rst_ad_out", {24'd0, ad_out[0]}, 32'd0);
        chk("rst_fin_ocupado", {30'd0, fin[0], ocupado[0]}, 32'd0);
        chk("rst_dato_leido", {24'd0, dato_leido[0]}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Plain write.
        drive(0, 1'b1, 1'b0, 8'h21, 8'h45, 8'h00, k);
        expect_txn(0, k, 1'b1, 8'h00);
        drop(0);
        repeat (25) @(negedge clk);

        // Plain read.
        drive(0, 1'b0, 1'b1, 8'h43, 8'h00, 8'h37, k);
        expect_txn(0, k, 1'b0, 8'h37);
        drop(0);
        repeat (25) @(negedge clk);

        // Both requests together: write wins.
        drive(0, 1'b1, 1'b1, 8'h5A, 8'hC3, 8'h99, k);
        expect_txn(0, k, 1'b1, 8'h00);
        drop(0);
        repeat (25) @(negedge clk);

        // Held write plus an ignored pulse while busy; the held level restarts
        // after one idle cycle.
        drive(0, 1'b1, 1'b0, 8'h11, 8'h22, 8'h00, k);
        expect_txn(0, k, 1'b1, 8'h00);
        expect_txn(0, k + 21, 1'b1, 8'h00);
        repeat (5) @(negedge clk);
        lec[0] = 1'b1; dir_i[0] = 8'h99; dato_i[0] = 8'h77;
        @(negedge clk);
        lec[0] = 1'b0; dir_i[0] = 8'h11; dato_i[0] = 8'h22;
        repeat (16) @(negedge clk);
        esc[0] = 1'b0;
        repeat (25) @(negedge clk);

        // Asynchronous reset in the middle of the data strobe.
        drive(0, 1'b1, 1'b0, 8'h33, 8'h66, 8'h00, k);
        drop(0);
        repeat (14) @(negedge clk);
        chk("pre_abort_d_strobe", {30'd0, wr_n[0], a_d[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_strobes_cs", {29'd0, cs_n[0], wr_n[0], rd_n[0]}, 32'd7);
        chk("abort_ad_oe_ocupado", {30'd0, ad_oe[0], ocupado[0]}, 32'd0);
        last_rd[0] = 8'h00;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'h44, 8'h88, 8'h00, k);
        expect_txn(0, k, 1'b1, 8'h00);
        drop(0);
        repeat (25) @(negedge clk);

        // Minimum-timing instance: read then write.
        drive(1, 1'b0, 1'b1, 8'h0F, 8'h00, 8'hA5, k);
        expect_txn(1, k, 1'b0, 8'hA5);
        drop(1);
        repeat (12) @(negedge clk);
        drive(1, 1'b1, 1'b0, 8'hE1, 8'h3C, 8'h00, k);
        expect_txn(1, k, 1'b1, 8'h00);
        drop(1);
        repeat (12) @(negedge clk);

        chk("sb_drained_dut0", q0.size(), 32'd0);
        chk("sb_drained_dut1", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
